// File: rtl/dilithium_stream_pkg.sv
// Shared definitions for the Dilithium host stream adapters.
//   - stream/counter/occupancy widths
//   - mode and adapter FSM state enums
//   - fixed-part length lookup over (mode, sec_lvl) and a config legality check
package dilithium_stream_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 30;
  localparam int unsigned OCC_W  = 2;

  // The length word L sits one word after the end of the fixed part.
  localparam int unsigned LEN_WORD_IDX = 1;

  typedef enum logic [1:0] {
    MODE_KEYGEN  = 2'd0,
    MODE_VERIFY  = 2'd1,
    MODE_SIGN    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIXED = 3'd1,
    ST_LEN   = 3'd2,
    ST_MSG   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Only security levels 2, 3 and 5 exist; mode 3 is reserved.
  function automatic logic cfg_legal(input mode_e m, input logic [2:0] sl);
    logic sl_ok;
    sl_ok = (sl == 3'd2) || (sl == 3'd3) || (sl == 3'd5);
    return sl_ok && (m != MODE_ILLEGAL);
  endfunction

  // Fixed-part length in 64-bit words; 0 for an illegal configuration.
  function automatic logic [CNT_W-1:0] fixed_words(input mode_e m, input logic [2:0] sl);
    logic [CNT_W-1:0] f;
    f = '0;
    unique case (m)
      MODE_KEYGEN: f = CNT_W'(4);
      MODE_VERIFY: begin
        unique case (sl)
          3'd2:    f = CNT_W'(164 + 303);
          3'd3:    f = CNT_W'(244 + 412);
          3'd5:    f = CNT_W'(324 + 575);
          default: f = '0;
        endcase
      end
      MODE_SIGN: begin
        unique case (sl)
          3'd2:    f = CNT_W'(316);
          3'd3:    f = CNT_W'(500);
          3'd5:    f = CNT_W'(608);
          default: f = '0;
        endcase
      end
      default: f = '0;
    endcase
    if (!cfg_legal(m, sl)) f = '0;
    return f;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry pass-through buffer between the host stream and the core.
//   clk, rst     : clock, async active-high reset (discards contents)
//   in_push      : write in_data this cycle (caller guarantees room)
//   in_data      : beat to store
//   out_ready    : downstream ready
//   out_valid    : registered, head entry present
//   out_data     : registered head entry, stable until consumed
//   occ_next_c   : occupancy after this cycle's push/pop (combinational)
module skid_buffer
  import dilithium_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_push,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occ_next_c
);

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              valid_q, valid_d;
  logic              pop;

  // Next occupancy and entry movement; head only changes on pop or when empty.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    pop    = valid_q && out_ready;
    unique case ({in_push, pop})
      2'b10: begin
        if (occ_q == OCC_W'(0)) head_d = in_data;
        else                    tail_d = in_data;
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == OCC_W'(2)) begin
          head_d = tail_q;
          tail_d = in_data;
        end else begin
          head_d = in_data;
        end
      end
      default: ;
    endcase
    valid_d = (occ_d != OCC_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = head_q;
  assign occ_next_c = occ_d;

endmodule

// File: rtl/input_stream_adapter.sv
// Host-to-core input stream adapter with frame length checking.
//   clk, rst            : clock, async active-high reset
//   start, mode, sec_lvl: frame start strobe and configuration (sampled in IDLE)
//   s_valid/s_ready/s_data/s_last : 64-bit host input stream
//   core_valid/core_ready/core_data : stream to combined_top
//   done                : one-cycle pulse at frame completion
//   len_error           : sticky length/config error, cleared by next start
module input_stream_adapter
  import dilithium_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [2:0]        sec_lvl,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              core_valid,
  input  logic              core_ready,
  output logic [DATA_W-1:0] core_data,
  output logic              done,
  output logic              len_error
);

  state_e           state_q, state_d, state_nxt;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             s_ready_q, s_ready_d;

  logic             accept;
  logic             fwd_push;
  logic             is_final;
  logic             len_hi_bad;
  logic [32:0]      len_sum;
  logic [CNT_W-1:0] msg_words;
  logic [OCC_W-1:0] occ_next_c;

  skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_push    (fwd_push),
    .in_data    (s_data),
    .out_ready  (core_ready),
    .out_valid  (core_valid),
    .out_data   (core_data),
    .occ_next_c (occ_next_c)
  );

  // Frame sequencing and per-beat length checks.
  always_comb begin
    state_nxt = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fwd_push  = 1'b0;
    accept    = s_valid && s_ready_q;
    len_hi_bad = |s_data[63:32];
    len_sum    = 33'(s_data[31:0]) + 33'd7;
    msg_words  = CNT_W'(len_sum >> 3);
    is_final   = ((state_q == ST_FIXED) && (cnt_q == CNT_W'(1)) && (mode_q == MODE_KEYGEN)) ||
                 ((state_q == ST_LEN)   && (msg_words == '0)) ||
                 ((state_q == ST_MSG)   && (cnt_q == CNT_W'(1)));

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode_e'(mode);
          err_d  = 1'b0;
          if (!cfg_legal(mode_e'(mode), sec_lvl)) begin
            err_d     = 1'b1;
            state_nxt = ST_DRAIN;
          end else begin
            cnt_d     = fixed_words(mode_e'(mode), sec_lvl);
            state_nxt = ST_FIXED;
          end
        end
      end
      ST_FIXED, ST_LEN, ST_MSG: begin
        if (accept) begin
          fwd_push = 1'b1;
          if ((state_q == ST_LEN) && len_hi_bad) begin
            // Oversized L: nothing after it can be trusted.
            err_d     = 1'b1;
            state_nxt = s_last ? ST_DONE : ST_DRAIN;
          end else if (s_last && !is_final) begin
            // Short frame; the core is left waiting, host must reset.
            err_d     = 1'b1;
            state_nxt = ST_DONE;
          end else if (is_final) begin
            state_nxt = ST_DONE;
            if (!s_last) begin
              err_d     = 1'b1;
              state_nxt = ST_DRAIN;
            end
          end else if (state_q == ST_FIXED && cnt_q == CNT_W'(1)) begin
            state_nxt = ST_LEN;
          end else if (state_q == ST_LEN) begin
            cnt_d     = msg_words;
            state_nxt = ST_MSG;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (accept && s_last) state_nxt = ST_DONE;
      end
      ST_DONE: ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Completion once the buffer runs dry; registered ready from next state/occupancy.
  always_comb begin
    state_d = state_nxt;
    done_d  = 1'b0;
    if ((state_nxt == ST_DONE) && (occ_next_c == OCC_W'(0))) begin
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end
    unique case (state_d)
      ST_FIXED, ST_LEN, ST_MSG: s_ready_d = (occ_next_c < OCC_W'(2));
      ST_DRAIN:                 s_ready_d = 1'b1;
      default:                  s_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_KEYGEN;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign done      = done_q;
  assign len_error = err_q;

endmodule

// File: tb/tb_input_stream_adapter.sv
// Self-checking bench for input_stream_adapter: forwarded beats are scored
// against a queue filled by the host driver; done/len_error checked per frame.
module tb_input_stream_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [2:0]  sec_lvl = 3'd2;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        core_valid;
  logic        core_ready = 1'b1;
  logic [63:0] core_data;
  logic        done;
  logic        len_error;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] beats[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int out_cnt = 0;
  int last_out_cyc = 0;
  int last_acc_cyc = 0;
  int rdy_mode = 0;
  bit chk_lat = 0;

  input_stream_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .sec_lvl    (sec_lvl),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .core_data  (core_data),
    .done       (done),
    .len_error  (len_error)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_ready();
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       core_ready = 1'b1;
        1:       core_ready = ~core_ready;
        default: core_ready = 1'b0;
      endcase
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (core_valid === 1'b1 && core_ready === 1'b1) begin
        out_cnt++;
        last_out_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: core_data=%h forwarded, required no beat", core_data);
        end else begin
          e = exp_q.pop_front();
          if (core_data !== e.data) begin
            errors++;
            $display("FAIL beat_data: core_data=%h, required %h", core_data, e.data);
          end
          if (chk_lat) begin
            checks++;
            if (cyc != e.cyc) begin
              errors++;
              $display("FAIL beat_latency: output cycle %0d, required %0d", cyc, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [2:0] sl);
    @(posedge clk); #1;
    start = 1'b1; mode = m; sec_lvl = sl;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_beats(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
  endtask

  // Offer every beat in 'beats'; the first n_fwd accepted beats are expected at the core.
  task automatic send_beats(input int last_at, input int n_fwd);
    for (int i = 0; i < beats.size(); i++) begin
      int guard;
      s_valid = 1'b1;
      s_data  = beats[i];
      s_last  = (i == last_at);
      guard   = 0;
      forever begin
        @(negedge clk);
        if (s_ready === 1'b1) break;
        guard++;
        if (guard > 200) break;
      end
      if (s_ready !== 1'b1) begin
        checks++; errors++;
        $display("FAIL accept_timeout: beat %0d s_ready=%b, required 1", i, s_ready);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      last_acc_cyc = cyc;
      if (i < n_fwd) exp_q.push_back('{data: beats[i], cyc: cyc + 1});
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    int guard = 0;
    while (done_cnt == base && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    ok = (done_cnt != base);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: %b, required 0", s_ready); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL reset_core_valid: %b, required 0", core_valid); end
    checks++; if (core_data !== 64'd0) begin errors++; $display("FAIL reset_core_data: %h, required 0", core_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b, required 0", done); end
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL reset_len_error: %b, required 0", len_error); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_keygen();
    int d0, o0; bit ok;
    d0 = done_cnt; o0 = out_cnt;
    rdy_mode = 0; chk_lat = 1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready: %b, required 0", s_ready); end
    fill_beats(4);
    do_start(2'd0, 3'd2);
    send_beats(3, 4);
    wait_done(d0, ok);
    chk_lat = 0;
    checks++; if (!ok) begin errors++; $display("FAIL keygen_done: no done pulse, required 1"); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL keygen_done_count: %0d pulses, required 1", done_cnt - d0); end
    checks++; if (out_cnt - o0 != 4) begin errors++; $display("FAIL keygen_beats: %0d forwarded, required 4", out_cnt - o0); end
    checks++; if (done_cyc != last_out_cyc + 1) begin errors++; $display("FAIL keygen_done_timing: cycle %0d, required %0d", done_cyc, last_out_cyc + 1); end
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL keygen_len_error: %b, required 0", len_error); end
  endtask

  task automatic test_sign_backpressure();
    int d0, o0; bit ok;
    d0 = done_cnt; o0 = out_cnt;
    rdy_mode = 1;
    fill_beats(500);
    beats.push_back(64'd13);
    beats.push_back({$urandom, $urandom});
    beats.push_back({$urandom, $urandom});
    do_start(2'd2, 3'd3);
    send_beats(502, 503);
    wait_done(d0, ok);
    rdy_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL sign_done: no done pulse, required 1"); end
    checks++; if (out_cnt - o0 != 503) begin errors++; $display("FAIL sign_beats: %0d forwarded, required 503", out_cnt - o0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sign_pending: %0d beats missing, required 0", exp_q.size()); end
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL sign_len_error: %b, required 0", len_error); end
  endtask

  task automatic test_verify_empty();
    int d0, o0; bit ok;
    d0 = done_cnt; o0 = out_cnt;
    fill_beats(899);
    beats.push_back(64'd0);
    do_start(2'd1, 3'd5);
    send_beats(899, 900);
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL verify_done: no done pulse, required 1"); end
    checks++; if (out_cnt - o0 != 900) begin errors++; $display("FAIL verify_beats: %0d forwarded, required 900", out_cnt - o0); end
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL verify_len_error: %b, required 0", len_error); end
  endtask

  task automatic test_early_last();
    int d0, o0; bit ok;
    d0 = done_cnt; o0 = out_cnt;
    fill_beats(2);
    do_start(2'd0, 3'd3);
    send_beats(1, 2);
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL early_done: no done pulse, required 1"); end
    checks++; if (out_cnt - o0 != 2) begin errors++; $display("FAIL early_beats: %0d forwarded, required 2", out_cnt - o0); end
    checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL early_len_error: %b, required 1", len_error); end
  endtask

  task automatic test_missing_last();
    int d0, o0; bit ok;
    d0 = done_cnt; o0 = out_cnt;
    fill_beats(7);
    do_start(2'd0, 3'd2);
    send_beats(6, 4);
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL missing_done: no done pulse, required 1"); end
    checks++; if (out_cnt - o0 != 4) begin errors++; $display("FAIL missing_beats: %0d forwarded, required 4", out_cnt - o0); end
    checks++; if (done_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL missing_done_timing: cycle %0d, required %0d", done_cyc, last_acc_cyc + 1); end
    checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL missing_len_error: %b, required 1", len_error); end
  endtask

  task automatic test_illegal_cfg();
    int d0, o0; bit ok;
    d0 = done_cnt; o0 = out_cnt;
    fill_beats(3);
    do_start(2'd3, 3'd2);
    checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL illegal_err_at_start: %b, required 1", len_error); end
    send_beats(2, 0);
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL illegal_done: no done pulse, required 1"); end
    checks++; if (out_cnt != o0) begin errors++; $display("FAIL illegal_beats: %0d forwarded, required 0", out_cnt - o0); end
    checks++; if (done_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL illegal_done_timing: cycle %0d, required %0d", done_cyc, last_acc_cyc + 1); end
    checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL illegal_len_error: %b, required 1", len_error); end
  endtask

  task automatic test_reset_mid_frame();
    fill_beats(6);
    do_start(2'd2, 3'd2);
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL start_clears_err: %b, required 0", len_error); end
    send_beats(-1, 6);
    rdy_mode = 2; core_ready = 1'b0;
    s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (core_valid !== 1'b1) begin errors++; $display("FAIL midframe_valid: %b, required 1", core_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: %b, required 0", s_ready); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL rst_core_valid: %b, required 0", core_valid); end
    checks++; if (core_data !== 64'd0) begin errors++; $display("FAIL rst_core_data: %h, required 0", core_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: %b, required 0", done); end
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL rst_len_error: %b, required 0", len_error); end
    exp_q.delete();
    s_valid = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_after_reset();
    int d0, o0; bit ok;
    d0 = done_cnt; o0 = out_cnt;
    fill_beats(4);
    do_start(2'd0, 3'd5);
    send_beats(3, 4);
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL post_rst_done: no done pulse, required 1"); end
    checks++; if (out_cnt - o0 != 4) begin errors++; $display("FAIL post_rst_beats: %0d forwarded, required 4", out_cnt - o0); end
    checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL post_rst_len_error: %b, required 0", len_error); end
  endtask

  initial begin
    fork
      drive_ready();
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_keygen();
    test_sign_backpressure();
    test_verify_empty();
    test_early_last();
    test_missing_last();
    test_illegal_cfg();
    test_reset_mid_frame();
    test_after_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_stream_adapter.md
# input_stream_adapter

Input-side companion of the output stream adapter in the Dilithium top level. It accepts the host's 64-bit valid/ready/last input stream and forwards it to `combined_top`'s `valid_i`/`ready_i`/`data_i` port. While forwarding, it checks the frame length against the layout implied by `mode`/`sec_lvl`. A malformed frame is flagged, never forwarded past its expected length, and drained up to the host's `last`.

## Interface
- No parameters. Frame-layout constants live in `dilithium_stream_pkg`.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle strobe from the start edge detector; ignored unless in IDLE.
- `mode`  in  2  0 keygen, 1 verify, 2 sign, 3 illegal; sampled on `start`.
- `sec_lvl`  in  3  2, 3 or 5 legal; sampled on `start`.
- `s_valid`  in  1  host beat valid.
- `s_ready`  out  1  adapter can accept a beat.
- `s_data`  in  64  host beat.
- `s_last`  in  1  final host beat of the frame.
- `core_valid`  out  1  to `combined_top.valid_i`.
- `core_ready`  in  1  from `combined_top.ready_i`.
- `core_data`  out  64  to `combined_top.data_i`.
- `done`  out  1  one-cycle pulse when the frame completes, good or bad.
- `len_error`  out  1  sticky error flag; cleared on the next accepted `start`.

## Operation
Frame layout, in 64-bit words, with each field zero-padded to whole words:
- Keygen: the fixed part only, which is the seed, F = 4.
- Verify: the fixed part is pk+sig, F = 164+303 / 244+412 / 324+575 for sec_lvl 2/3/5. It is followed by one length word L and then W message words.
- Sign: the fixed part is sk, F = 316 / 500 / 608. It is followed by L and W words.
- L is the message byte count. W = (L + 7) >> 3. L[63:32] must be 0.

FSM states: IDLE, FIXED, LEN, MSG, DRAIN, DONE.
- IDLE: `s_ready` = 0. On `start`:
  - if mode or sec_lvl is illegal, set `len_error` and go to DRAIN;
  - otherwise load the counter with F and go to FIXED.
- FIXED: each accepted beat is forwarded and decrements the counter. On the final word:
  - keygen goes to DONE;
  - other modes go to LEN.
- LEN: the accepted beat is forwarded. The adapter computes W.
  - If L[63:32] ≠ 0, it sets the error and goes to DRAIN.
  - If W = 0, it goes to DONE.
  - Otherwise it loads the counter with W and goes to MSG.
- MSG: each beat is forwarded and decrements the counter. It goes to DONE on the final word.
- DRAIN: `s_ready` = 1. Beats are discarded, not forwarded. On the beat with `s_last` it goes to DONE.
- DONE: pulses `done` once the skid buffer is empty, then returns to IDLE.

Length checks, made on every accepted beat:
- `s_last` on a non-final beat sets `len_error`. That beat is forwarded, then the FSM goes to DONE. The core is left short; recovery is the host's responsibility via `rst`.
- The final expected beat arriving without `s_last` sets `len_error`. The beat is forwarded, then the FSM goes to DRAIN.

Counter: 30 bits, unsigned, decrement only, never wraps, because the load value is at least 1.

## Timing
- Reset values: `s_ready` = 0, `core_valid` = 0, `core_data` = 0, `done` = 0, `len_error` = 0. The FSM is in IDLE with the buffer empty.
- Pass-through is a 2-entry skid buffer:
  - 1-cycle latency from `s_valid && s_ready` to `core_valid`;
  - one beat per cycle sustained when `core_ready` = 1;
  - `s_ready` is registered and depends only on buffer occupancy and state.
- Handshake rules:
  - `core_valid` and `core_data` are held stable until `core_ready`.
  - A beat transfers when valid && ready in the same cycle.
- Simultaneous events:
  - An acceptance and a drain in the same cycle keep occupancy unchanged.
  - `start` arriving in any state other than IDLE is ignored.
- `done` is asserted the cycle after the last forwarded beat leaves the buffer. On an illegal-config frame it is asserted the cycle after the drained `s_last`.
- `rst` mid-frame returns the FSM to IDLE asynchronously and discards buffered beats.

## Structure
- `dilithium_stream_pkg` holds:
  - the mode enum;
  - the state enum;
  - the F lookup function over (mode, sec_lvl);
  - a constant for the length-word index.
- One sub-module, `skid_buffer` (64-bit data, 2 entries), is instantiated once. The FSM and checks stay in the top module.

## Test plan
- **Keygen:** `start`, mode = 0, sec_lvl = 2, 4 beats with last on beat 4, `core_ready` = 1 → 4 beats forwarded, back to back, at 1-cycle latency; `done` pulses; `len_error` = 0.
- **Sign, backpressure:** mode = 2, sec_lvl = 3, 500 sk words, L = 13, then 2 message words with last. `core_ready` toggles 1010… → 503 beats delivered in order, no loss or duplication; `done` pulses.
- **Verify, empty message:** mode = 1, sec_lvl = 5, 899 words, then L = 0 with last → 900 beats forwarded; `done`; no error.
- **Early last:** keygen with last on beat 2 → 2 beats forwarded; `len_error` = 1; `done` pulses.
- **Missing last:** keygen sending 7 beats with last on beat 7 → 4 beats forwarded, 3 drained; `len_error` = 1; `done` after beat 7.
- **Illegal config and reset:** mode = 3 → no beats forwarded; error; drains to last. Then assert `rst` mid-frame of a sign → all outputs at their reset values the same cycle; a new `start` clears `len_error`.
